// File: rtl/control_sumador_serie.sv
// Bit-serial N-bit unsigned adder controller time-sharing one external half adder.
// Latency: 2N+1 cycles from accepted start to the done pulse; 2N+2 cycles per addition.
// No backpressure: start is only honoured in REPOSO and ignored while busy or in FIN.

// Shared combinational half adder (the resource being time-shared).
module medio_sumador (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module control_sumador_serie #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ha_a,
    output logic         ha_b,
    input  logic         ha_s,
    input  logic         ha_c,
    output logic [N-1:0] suma,
    output logic         cout,
    output logic         busy,
    output logic         done
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        FASE1  = 2'd1,
        FASE2  = 2'd2,
        FIN    = 2'd3
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [N-1:0]   a_reg_q, a_reg_d;
    logic [N-1:0]   b_reg_q, b_reg_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           x_q, x_d;
    logic           c1_q, c1_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   suma_q, suma_d;
    logic           cout_q, cout_d;

    // Next-state, datapath updates and half-adder drive, decoded from the current state
    always_comb begin
        estado_d = estado_q;
        a_reg_d  = a_reg_q;
        b_reg_d  = b_reg_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        x_d      = x_q;
        c1_d     = c1_q;
        res_d    = res_q;
        suma_d   = suma_q;
        cout_d   = cout_q;
        ha_a     = 1'b0;
        ha_b     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (estado_q)
            REPOSO: begin
                if (start) begin
                    a_reg_d  = a;
                    b_reg_d  = b;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    estado_d = FASE1;
                end
            end
            FASE1: begin
                // First pass: operand bits, giving partial sum and first carry
                busy     = 1'b1;
                ha_a     = a_reg_q[idx_q];
                ha_b     = b_reg_q[idx_q];
                x_d      = ha_s;
                c1_d     = ha_c;
                estado_d = FASE2;
            end
            FASE2: begin
                // Second pass: partial sum plus running carry; the two carries are exclusive
                busy         = 1'b1;
                ha_a         = x_q;
                ha_b         = carry_q;
                res_d[idx_q] = ha_s;
                carry_d      = c1_q | ha_c;
                if (idx_q == IW'(N - 1)) begin
                    suma_d   = res_d;
                    cout_d   = carry_d;
                    estado_d = FIN;
                end else begin
                    idx_d    = idx_q + IW'(1);
                    estado_d = FASE1;
                end
            end
            FIN: begin
                done     = 1'b1;
                estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            a_reg_q  <= '0;
            b_reg_q  <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            x_q      <= 1'b0;
            c1_q     <= 1'b0;
            res_q    <= '0;
            suma_q   <= '0;
            cout_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_reg_q  <= a_reg_d;
            b_reg_q  <= b_reg_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            x_q      <= x_d;
            c1_q     <= c1_d;
            res_q    <= res_d;
            suma_q   <= suma_d;
            cout_q   <= cout_d;
        end
    end

    assign suma = suma_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_control_sumador_serie.sv
// Testbench for control_sumador_serie wired to a real medio_sumador.
// Reference model tracks the operation as a cycle count and computes expectations arithmetically.
// Stimulus drives on the falling edge; outputs are checked 2 ns after the rising edge.
module tb_control_sumador_serie;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ha_a, ha_b, ha_s, ha_c;
    logic [N-1:0] suma;
    logic         cout, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_sumador_serie #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ha_a(ha_a), .ha_b(ha_b), .ha_s(ha_s), .ha_c(ha_c),
        .suma(suma), .cout(cout), .busy(busy), .done(done)
    );

    medio_sumador u_ha (.a(ha_a), .b(ha_b), .s(ha_s), .c(ha_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: cnt=0 idle, 1..2N working (odd = first pass, even = second pass), 2N+1 finished
    int       m_cnt = 0;
    int       m_a = 0;
    int       m_b = 0;
    int       m_suma = 0;
    int       m_cout = 0;
    int       busy_run = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt = 0; m_suma = 0; m_cout = 0; busy_run = 0;
            end else if (m_cnt == 0) begin
                if (start) begin
                    m_cnt = 1; m_a = int'(a); m_b = int'(b);
                end
            end else if (m_cnt == 2*N + 1) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == 2*N + 1) begin
                    m_suma = (m_a + m_b) % (1 << N);
                    m_cout = (m_a + m_b) >> N;
                end
            end
            #2;
            if (rst_n) begin
                int exp_ha_a, exp_ha_b, j, msk;
                exp_ha_a = 0; exp_ha_b = 0;
                if (m_cnt >= 1 && m_cnt <= 2*N) begin
                    j = (m_cnt - 1) / 2;
                    if (m_cnt % 2 == 1) begin
                        exp_ha_a = (m_a >> j) & 1;
                        exp_ha_b = (m_b >> j) & 1;
                    end else begin
                        msk = (1 << j) - 1;
                        exp_ha_a = ((m_a ^ m_b) >> j) & 1;
                        exp_ha_b = (((m_a & msk) + (m_b & msk)) >> j) & 1;
                    end
                end
                check("busy", 32'(busy), 32'((m_cnt >= 1 && m_cnt <= 2*N) ? 1 : 0));
                check("done", 32'(done), 32'((m_cnt == 2*N + 1) ? 1 : 0));
                check("ha_a", 32'(ha_a), 32'(exp_ha_a));
                check("ha_b", 32'(ha_b), 32'(exp_ha_b));
                check("suma", 32'(suma), 32'(m_suma));
                check("cout", 32'(cout), 32'(m_cout));
                if (busy) busy_run++;
                if (done) begin
                    check("busy_len", 32'(busy_run), 32'(2*N));
                    busy_run = 0;
                end
            end
        end
    end

    // Wait (on falling edges) until done is seen; an expired budget is a failure
    task automatic wait_done(input bit scramble, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4*N; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (scramble) begin
                a = N'($urandom); b = N'($urandom); start = 1'($urandom);
            end
        end
        if (!ok) check("done_timeout", 32'(0), 32'(1));
    endtask

    // One addition: mode 0 = one-cycle start, 1 = start left high, 2 = inputs scrambled while busy
    task automatic run_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input int mode,
                          input logic [N-1:0] es, input logic ec, input string tag);
        bit ok;
        int cyc;
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        @(negedge clk);
        if (mode != 1) start = 1'b0;
        if (mode == 2) begin a = N'($urandom); b = N'($urandom); end
        cyc = 1;
        ok = 1'b0;
        for (int k = 0; k < 4*N; k++) begin
            if (done) begin ok = 1'b1; break; end
            if (mode == 2) begin a = N'($urandom); b = N'($urandom); start = 1'($urandom); end
            @(negedge clk);
            cyc++;
        end
        if (!ok) check({tag, "_timeout"}, 32'(0), 32'(1));
        else begin
            check({tag, "_latency"}, 32'(cyc), 32'(2*N + 1));
            check({tag, "_suma"}, 32'(suma), 32'(es));
            check({tag, "_cout"}, 32'(cout), 32'(ec));
        end
        if (mode == 2) start = 1'b0;
    endtask

    initial begin
        bit ok;
        int ra, rb;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_suma", 32'(suma), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_ha", 32'({ha_a, ha_b}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h00, 8'h00, 0, 8'h00, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 0, 8'h00, 1'b1, "ripple");
        run_op(8'hA5, 8'h5A, 0, 8'hFF, 1'b0, "alt");

        // Start held high across two operations; second accept only from REPOSO
        run_op(8'h80, 8'h80, 1, 8'h00, 1'b1, "msb");
        a = 8'h3C; b = 8'h0F;
        @(negedge clk);
        check("fin_exit_busy", 32'(busy), 32'(0));
        wait_done(1'b0, ok);
        start = 1'b0;
        if (ok) begin
            check("held_suma", 32'(suma), 32'(8'h4B));
            check("held_cout", 32'(cout), 32'(0));
        end
        @(negedge clk);

        run_op(8'h12, 8'h34, 2, 8'h46, 1'b0, "toggle");
        @(negedge clk);

        // Asynchronous reset in the second pass of bit 3
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_suma", 32'(suma), 32'(0));
        check("arst_cout", 32'(cout), 32'(0));
        check("arst_ha", 32'({ha_a, ha_b}), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h01, 8'h02, 0, 8'h03, 1'b0, "post_rst");

        for (int t = 0; t < 12; t++) begin
            ra = int'($urandom_range(255));
            rb = int'($urandom_range(255));
            run_op(N'(ra), N'(rb), int'($urandom_range(1)) * 2, N'((ra + rb) % 256),
                   1'((ra + rb) >> 8), "rand");
            repeat ($urandom_range(2)) @(negedge clk);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sumador_serie.md
Name: control_sumador_serie

Overview:
Controller that time-shares a single external medio_sumador instance to perform an N-bit unsigned addition bit-serially, LSB first. Each bit takes two half-adder passes: operand bits first, then partial sum with the running carry. The block sits between a requesting unit and the shared medio_sumador: it drives the half-adder inputs, samples its outputs, and assembles the N-bit sum plus carry-out.

Parameters:
N, 8, operand and sum width in bits (N >= 2)

Ports:
clk      input   1  clock, all state updates on rising edge
rst_n    input   1  asynchronous, active-low reset
start    input   1  request, sampled only in state REPOSO
a        input   N  operand A, captured when start is accepted
b        input   N  operand B, captured when start is accepted
ha_a     output  1  drives input A of the shared medio_sumador
ha_b     output  1  drives input B of the shared medio_sumador
ha_s     input   1  sum output S of the shared medio_sumador
ha_c     input   1  carry output Cout of the shared medio_sumador
suma     output  N  registered result, valid from done onward
cout     output  1  registered carry-out of the addition
busy     output  1  high in FASE1/FASE2
done     output  1  one-cycle pulse in FIN

Behaviour:
- Reset (rst_n=0, asynchronous): state=REPOSO; suma=0, cout=0, busy=0, done=0, ha_a=0, ha_b=0; internal operand registers, bit index, carry, x, c1 cleared. Reset mid-operation aborts it. No done is produced. suma/cout read 0.
- States: REPOSO, FASE1, FASE2, FIN. Encoding is free.
- REPOSO: ha_a=ha_b=0. On an edge with start=1, latch a/b into a_reg/b_reg, set i=0 and carry=0, then go to FASE1. Otherwise stay.
- FASE1: ha_a=a_reg[i], ha_b=b_reg[i] (combinational from state). At the edge, x<=ha_s, c1<=ha_c, then go to FASE2.
- FASE2: ha_a=x, ha_b=carry. At the edge, res[i]<=ha_s and carry<=c1|ha_c (c1 and ha_c are never both 1).
  - If i==N-1, go to FIN and copy the completed result to suma and the final carry to cout at this same edge.
  - Otherwise i<=i+1 and go to FASE1.
- FIN: done=1 for exactly one cycle, busy=0, ha_a=ha_b=0. The next edge unconditionally returns to REPOSO. start is ignored in FIN.
- The shared half adder is purely combinational. Its outputs are sampled in the same cycle that ha_a/ha_b are driven. No wait states.
- Latency: start accepted at edge 0. Bits are processed at edges 1..2N. FIN (done=1) holds during the cycle after edge 2N. suma/cout are valid from that cycle onward. REPOSO is re-entered at edge 2N+1. The earliest next accept is edge 2N+2. Throughput is 1 addition per 2N+2 cycles.
- start high while busy or in FIN is ignored. Operand changes on a/b after acceptance have no effect.
- suma/cout hold the last completed result until the next FASE2→FIN transition or reset. Intermediate bits never appear on suma.
- Arithmetic is unsigned modulo 2^N, with cout = bit N of a+b.
- i ranges 0..N-1 and needs ceil(log2 N) bits. There is no wrap beyond N-1.

Test Plan:
- Bench wiring: the bench instantiates the real medio_sumador and connects ha_a/ha_b/ha_s/ha_c. All checks use N=8 and clk period 10 ns.
- 8'h00+8'h00, start one cycle -> done pulses at cycle 17 after accept; suma=8'h00, cout=0; busy high for exactly 16 cycles.
- 8'hFF+8'h01 -> suma=8'h00, cout=1 (full carry ripple through all bits). Separately, 8'hA5+8'h5A -> suma=8'hFF, cout=0.
- 8'h80+8'h80 -> suma=8'h00, cout=1. Then 8'h3C+8'h0F with start held high continuously -> second accept occurs only from REPOSO. Second result is suma=8'h4B, cout=0. done pulses exactly once per operation.
- Start 8'h12+8'h34 and toggle a/b and start during busy -> result remains 8'h46, cout=0. No extra accept occurs before REPOSO.
- Start 8'hFF+8'hFF, assert rst_n=0 asynchronously mid-FASE2 of bit 3 -> outputs go to 0 immediately without waiting for an edge. No done is produced. After release, 8'h01+8'h02 -> suma=8'h03, cout=0.
- Throughout every test, ha_a=ha_b=0 in REPOSO and FIN. In FASE1, ha_a/ha_b must equal the latched operand bits for the current index.
